// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: LDR writebacks take priority, colliding ALU writebacks
// wait in a 2-entry in-order queue that coalesces repeat writes to the same register.
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_w_en,
    input  logic [3:0]  alu_w_addr,
    input  logic [31:0] alu_w_data,
    input  logic        ldr_w_en,
    input  logic [3:0]  ldr_w_addr,
    input  logic [31:0] ldr_w_data,
    output logic        rf_w_en,
    output logic [3:0]  rf_w_addr,
    output logic [31:0] rf_w_data,
    output logic        stall,
    output logic [1:0]  q_count,
    output logic        overflow_err
);

    typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} q_state_e;

    q_state_e          state_q, state_d;
    logic [1:0][3:0]   addr_q, addr_d;
    logic [1:0][31:0]  data_q, data_d;
    logic              rf_en_q, rf_en_d;
    logic [3:0]        rf_addr_q, rf_addr_d;
    logic [31:0]       rf_data_q, rf_data_d;
    logic              stall_q;
    logic              ovf_q, ovf_d;

    logic              valid0, valid1, ldr_sup, grant_ldr, deq, bypass;
    logic [1:0]        cnt;

    assign valid0    = (state_q != StEmpty);
    assign valid1    = (state_q == StFull);
    // A queued ALU write is younger than an LDR result to the same register.
    assign ldr_sup   = ldr_w_en && ((valid0 && addr_q[0] == ldr_w_addr) ||
                                    (valid1 && addr_q[1] == ldr_w_addr));
    assign grant_ldr = ldr_w_en && !ldr_sup;
    assign deq       = !grant_ldr && valid0;
    assign bypass    = !grant_ldr && !valid0 && alu_w_en;

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        cnt       = state_q;
        ovf_d     = ovf_q;
        rf_en_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;

        if (grant_ldr) begin
            rf_en_d   = 1'b1;
            rf_addr_d = ldr_w_addr;
            rf_data_d = ldr_w_data;
        end else if (deq) begin
            rf_en_d   = 1'b1;
            rf_addr_d = addr_q[0];
            rf_data_d = data_q[0];
        end else if (bypass) begin
            rf_en_d   = 1'b1;
            rf_addr_d = alu_w_addr;
            rf_data_d = alu_w_data;
        end

        if (deq) begin
            addr_d[0] = addr_q[1];
            data_d[0] = data_q[1];
            cnt       = cnt - 2'd1;
        end

        // Matching against the post-dequeue queue turns a hit on the leaving head into a re-append.
        if (alu_w_en && !bypass) begin
            if (cnt >= 2'd1 && addr_d[0] == alu_w_addr) begin
                data_d[0] = alu_w_data;
            end else if (cnt == 2'd2 && addr_d[1] == alu_w_addr) begin
                data_d[1] = alu_w_data;
            end else if (cnt == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                addr_d[cnt[0]] = alu_w_addr;
                data_d[cnt[0]] = alu_w_data;
                cnt            = cnt + 2'd1;
            end
        end

        state_d = q_state_e'(cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEmpty;
            addr_q    <= '0;
            data_q    <= '0;
            rf_en_q   <= 1'b0;
            rf_addr_q <= 4'd0;
            rf_data_q <= 32'd0;
            stall_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rf_en_q   <= rf_en_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            stall_q   <= (state_d == StFull);
            ovf_q     <= ovf_d;
        end
    end

    assign rf_w_en      = rf_en_q;
    assign rf_w_addr    = rf_addr_q;
    assign rf_w_data    = rf_data_q;
    assign stall        = stall_q;
    assign q_count      = state_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a
// list-of-pending-writes reference model.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_w_en, ldr_w_en;
    logic [3:0]  alu_w_addr, ldr_w_addr;
    logic [31:0] alu_w_data, ldr_w_data;
    logic        rf_w_en, stall, overflow_err;
    logic [3:0]  rf_w_addr;
    logic [31:0] rf_w_data;
    logic [1:0]  q_count;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_w_en     (alu_w_en),
        .alu_w_addr   (alu_w_addr),
        .alu_w_data   (alu_w_data),
        .ldr_w_en     (ldr_w_en),
        .ldr_w_addr   (ldr_w_addr),
        .ldr_w_data   (ldr_w_data),
        .rf_w_en      (rf_w_en),
        .rf_w_addr    (rf_w_addr),
        .rf_w_data    (rf_w_data),
        .stall        (stall),
        .q_count      (q_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of pending ALU writes, oldest first.
    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         pend[$];
    logic        exp_en, exp_stall, exp_ovf;
    logic [3:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_cnt;

    function automatic void model_step(input logic r, input logic ae, input logic [3:0] aa,
                                       input logic [31:0] ad, input logic le,
                                       input logic [3:0] la, input logic [31:0] ld);
        bit   sup, alu_used, found;
        wr_t  g;
        if (r) begin
            pend.delete();
            exp_en = 0; exp_addr = 0; exp_data = 0; exp_ovf = 0; exp_stall = 0; exp_cnt = 0;
            return;
        end
        sup = 0;
        foreach (pend[i]) if (pend[i].a == la) sup = 1;
        exp_en   = 0;
        alu_used = 0;
        if (le && !sup) begin
            exp_en = 1; exp_addr = la; exp_data = ld;
        end else if (pend.size() > 0) begin
            g = pend.pop_front();
            exp_en = 1; exp_addr = g.a; exp_data = g.d;
        end else if (ae) begin
            exp_en = 1; exp_addr = aa; exp_data = ad; alu_used = 1;
        end
        if (ae && !alu_used) begin
            found = 0;
            foreach (pend[i]) if (pend[i].a == aa) begin pend[i].d = ad; found = 1; end
            if (!found) begin
                if (pend.size() < 2) pend.push_back('{a: aa, d: ad});
                else exp_ovf = 1;
            end
        end
        exp_cnt   = 2'(pend.size());
        exp_stall = (pend.size() == 2);
    endfunction

    task automatic drive(input logic r, input logic ae, input logic [3:0] aa,
                         input logic [31:0] ad, input logic le, input logic [3:0] la,
                         input logic [31:0] ld);
        rst = r; alu_w_en = ae; alu_w_addr = aa; alu_w_data = ad;
        ldr_w_en = le; ldr_w_addr = la; ldr_w_data = ld;
        model_step(r, ae, aa, ad, le, la, ld);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    endtask

    task automatic test_reset();
        drive(1, 1, 4'd7, 32'hDEAD, 1, 4'd8, 32'hBEEF);
        drive(1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        n_checks++;
        if ({rf_w_en, rf_w_addr, rf_w_data} !== 37'd0) begin
            n_errors++;
            $display("FAIL reset_port: got en=%b addr=%0d data=%h, want 0/0/0",
                     rf_w_en, rf_w_addr, rf_w_data);
        end
        n_checks++;
        if ({stall, q_count, overflow_err} !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_status: got stall=%b q=%0d ovf=%b, want 0/0/0",
                     stall, q_count, overflow_err);
        end
    endtask

    task automatic test_bypass();
        drive(0, 1, 4'd3, 32'h11, 0, 4'd0, 32'd0);
        n_checks++;
        if ({rf_w_en, rf_w_addr, rf_w_data, q_count} !== {1'b1, 4'd3, 32'h11, 2'd0}) begin
            n_errors++;
            $display("FAIL bypass: got en=%b addr=%0d data=%h q=%0d, want 1/3/11/0",
                     rf_w_en, rf_w_addr, rf_w_data, q_count);
        end
        idle();
        n_checks++;
        if (rf_w_en !== 1'b0) begin
            n_errors++;
            $display("FAIL bypass_idle: got en=%b, want 0", rf_w_en);
        end
    endtask

    task automatic test_collision();
        drive(0, 1, 4'd2, 32'hBB, 1, 4'd1, 32'hAA);
        n_checks++;
        if ({rf_w_en, rf_w_addr, rf_w_data, q_count} !== {1'b1, 4'd1, 32'hAA, 2'd1}) begin
            n_errors++;
            $display("FAIL collision_ldr: got en=%b addr=%0d data=%h q=%0d, want 1/1/aa/1",
                     rf_w_en, rf_w_addr, rf_w_data, q_count);
        end
        idle();
        n_checks++;
        if ({rf_w_en, rf_w_addr, rf_w_data, q_count} !== {1'b1, 4'd2, 32'hBB, 2'd0}) begin
            n_errors++;
            $display("FAIL collision_alu: got en=%b addr=%0d data=%h q=%0d, want 1/2/bb/0",
                     rf_w_en, rf_w_addr, rf_w_data, q_count);
        end
    endtask

    task automatic test_supersede();
        drive(0, 1, 4'd5, 32'h55, 1, 4'd6, 32'h66);
        drive(0, 0, 4'd0, 32'd0, 1, 4'd5, 32'h99);
        n_checks++;
        if ({rf_w_en, rf_w_addr, rf_w_data, q_count} !== {1'b1, 4'd5, 32'h55, 2'd0}) begin
            n_errors++;
            $display("FAIL supersede: got en=%b addr=%0d data=%h q=%0d, want 1/5/55/0",
                     rf_w_en, rf_w_addr, rf_w_data, q_count);
        end
        idle();
        n_checks++;
        if (rf_w_en !== 1'b0) begin
            n_errors++;
            $display("FAIL supersede_drop: got en=%b addr=%0d data=%h, want en=0",
                     rf_w_en, rf_w_addr, rf_w_data);
        end
    endtask

    task automatic test_coalesce();
        drive(0, 1, 4'd4, 32'h1, 1, 4'd7, 32'h77);
        drive(0, 1, 4'd4, 32'h2, 1, 4'd8, 32'h88);
        n_checks++;
        if ({rf_w_addr, rf_w_data, q_count} !== {4'd8, 32'h88, 2'd1}) begin
            n_errors++;
            $display("FAIL coalesce_hold: got addr=%0d data=%h q=%0d, want 8/88/1",
                     rf_w_addr, rf_w_data, q_count);
        end
        idle();
        n_checks++;
        if ({rf_w_en, rf_w_addr, rf_w_data, q_count} !== {1'b1, 4'd4, 32'h2, 2'd0}) begin
            n_errors++;
            $display("FAIL coalesce_write: got en=%b addr=%0d data=%h q=%0d, want 1/4/2/0",
                     rf_w_en, rf_w_addr, rf_w_data, q_count);
        end
        idle();
        n_checks++;
        if (rf_w_en !== 1'b0) begin
            n_errors++;
            $display("FAIL coalesce_single: got en=%b data=%h, want en=0", rf_w_en, rf_w_data);
        end
    endtask

    task automatic test_overflow();
        drive(0, 1, 4'd9, 32'h90, 1, 4'd1, 32'h10);
        drive(0, 1, 4'd10, 32'hA0, 1, 4'd2, 32'h20);
        n_checks++;
        if ({stall, q_count, overflow_err} !== {1'b1, 2'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL full_stall: got stall=%b q=%0d ovf=%b, want 1/2/0",
                     stall, q_count, overflow_err);
        end
        drive(0, 1, 4'd15, 32'hF0, 1, 4'd3, 32'h30);
        n_checks++;
        if ({overflow_err, q_count, stall} !== {1'b1, 2'd2, 1'b1}) begin
            n_errors++;
            $display("FAIL overflow: got ovf=%b q=%0d stall=%b, want 1/2/1",
                     overflow_err, q_count, stall);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            n_checks++;
            if (rf_w_en && rf_w_addr == 4'd15) begin
                n_errors++;
                $display("FAIL overflow_lost: got write r15=%h, want no write to r15", rf_w_data);
            end
        end
        n_checks++;
        if ({overflow_err, q_count} !== {1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL overflow_sticky: got ovf=%b q=%0d, want 1/0", overflow_err, q_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(0, 1, 4'd11, 32'hB1, 1, 4'd1, 32'h1);
        drive(0, 1, 4'd12, 32'hC1, 1, 4'd2, 32'h2);
        drive(1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        n_checks++;
        if ({q_count, stall, rf_w_en, overflow_err} !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_mid: got q=%0d stall=%b en=%b ovf=%b, want 0/0/0/0",
                     q_count, stall, rf_w_en, overflow_err);
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            n_checks++;
            if (rf_w_en !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_discard: got en=%b addr=%0d, want en=0", rf_w_en, rf_w_addr);
            end
        end
    endtask

    task automatic test_random();
        logic r, ae, le;
        logic [3:0] aa, la;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            ae = ($urandom_range(0, 3) != 0);
            le = ($urandom_range(0, 2) == 0);
            aa = 4'($urandom_range(0, 3)) + ((i % 2 == 0) ? 4'd12 : 4'd0);
            la = 4'($urandom_range(0, 3)) + ((i % 3 == 0) ? 4'd12 : 4'd0);
            drive(r, ae, aa, $urandom, le, la, $urandom);
            n_checks++;
            if ({rf_w_en, rf_w_addr, rf_w_data, stall, q_count, overflow_err} !==
                {exp_en, exp_addr, exp_data, exp_stall, exp_cnt, exp_ovf}) begin
                n_errors++;
                $display("FAIL random[%0d]: got en=%b a=%0d d=%h st=%b q=%0d ovf=%b, want %b %0d %h %b %0d %b",
                         i, rf_w_en, rf_w_addr, rf_w_data, stall, q_count, overflow_err,
                         exp_en, exp_addr, exp_data, exp_stall, exp_cnt, exp_ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b1; alu_w_en = 0; alu_w_addr = 0; alu_w_data = 0;
        ldr_w_en = 0; ldr_w_addr = 0; ldr_w_data = 0;
        test_reset();
        test_bypass();
        test_collision();
        test_supersede();
        test_coalesce();
        test_overflow();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
